// File: rtl/y_stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : y_stream_packer_if
// Description : Valid/ready word port carrying packed samples out of
//               y_stream_packer.
// Signals     : out_data  - packed word, first sample in bit 0
//               out_ones  - number of 1 bits in out_data
//               out_valid - out_data/out_ones hold an unaccepted word
//               out_ready - sink accepts the word this cycle
// Modports    : master (packer side), slave (consumer side)
// Revision    : 1.0 - initial release
// ============================================================================
interface y_stream_packer_if #(
  parameter int WIDTH = 8
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  out_data;
  logic [ONES_W-1:0] out_ones;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_ones,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ones,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/y_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : y_stream_packer
// Description : Samples serial bit y on en strobes, packs WIDTH samples
//               LSB-first into words offered on a valid/ready port, and keeps
//               rising-edge count, longest-1s-run and sticky overrun stats.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               en, y      - sample strobe and serial input bit
//               clr_stats  - synchronous clear of rise_cnt/run_max/overrun
//               ob         - word output port (master modport)
//               rise_cnt   - saturating count of 0->1 sample transitions
//               run_max    - saturating longest run of sampled 1s
//               overrun    - sticky, a completed word was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module y_stream_packer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 y,
  input  logic                 clr_stats,
  y_stream_packer_if.master    ob,
  output logic [15:0]          rise_cnt,
  output logic [7:0]           run_max,
  output logic                 overrun
);

  localparam int BC_W   = $clog2(WIDTH);
  localparam int ONES_W = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] c_last = BC_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_sh;
  logic [BC_W-1:0]   r_bc;
  logic              r_prev;
  logic [7:0]        r_run_cur;

  logic              w_complete;
  logic              w_load;
  logic              w_set_ovr;
  logic [WIDTH-1:0]  w_word;
  logic [ONES_W-1:0] w_ones;
  logic [7:0]        w_run_nxt;

  assign w_complete = en && (r_bc == c_last);

  // The completing word includes the bit being sampled on this edge, so
  // it is assembled combinationally from the shift register plus y.
  always_comb begin
    w_word       = r_sh;
    w_word[r_bc] = y;
    w_ones       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_word[i]);
    end
  end

  // Collector: partial bits beyond bc are stale but always overwritten
  // before the word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
      r_bc <= '0;
    end else if (en) begin
      r_sh[r_bc] <= y;
      r_bc       <= (r_bc == c_last) ? '0 : r_bc + BC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_set_ovr   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_complete && ob.out_ready) begin
          w_load = 1'b1;
        end else if (w_complete) begin
          w_set_ovr = 1'b1;
        end else if (ob.out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  assign ob.out_valid = (r_state == S_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      ob.out_data <= '0;
      ob.out_ones <= '0;
    end else if (w_load) begin
      ob.out_data <= w_word;
      ob.out_ones <= w_ones;
    end
  end

  assign w_run_nxt = y ? ((r_run_cur == 8'hFF) ? 8'hFF : r_run_cur + 8'd1) : 8'd0;

  // prev tracks the raw stream and is deliberately untouched by clr_stats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else if (en) begin
      r_prev <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      rise_cnt  <= '0;
      run_max   <= '0;
      r_run_cur <= '0;
    end else if (en) begin
      r_run_cur <= w_run_nxt;
      if (w_run_nxt > run_max) begin
        run_max <= w_run_nxt;
      end
      if (y && !r_prev && (rise_cnt != 16'hFFFF)) begin
        rise_cnt <= rise_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      overrun <= 1'b0;
    end else if (w_set_ovr) begin
      overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/y_stream_packer.md
# y_stream_packer

Downstream consumer of the state-machine serial output `y`. Samples `y` on a strobe, packs consecutive samples into WIDTH-bit words, and presents each word on a valid/ready output port. Keeps running statistics on the sampled stream: rising-edge count, longest run of 1s, and a sticky overrun flag. It sits between the Moore/Mealy FSM and any bus-side logger or checker that reads words instead of single bits.

## Interface
- `WIDTH`, default 8: samples per packed word (2..16).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: sample strobe; `y` is sampled only on edges where `en`=1.
- `y`  in  1: serial bit from the upstream FSM.
- `clr_stats`  in  1: synchronous clear of `rise_cnt`, `run_max` and `overrun`.
- `out_ready`  in  1: downstream accepts `out_data` this cycle.
- `out_data`  out  WIDTH: packed word; first sample is bit 0 (LSB-first).
- `out_ones`  out  $clog2(WIDTH+1): number of 1 bits in `out_data`.
- `out_valid`  out  1: `out_data`/`out_ones` hold an unaccepted word.
- `rise_cnt`  out  16: 0→1 transitions in the sampled stream, saturating at 16'hFFFF.
- `run_max`  out  8: longest run of consecutive sampled 1s, saturating at 255.
- `overrun`  out  1: sticky; a completed word was dropped.

## Operation
- Collector: shift register `sh` plus a bit counter `bc` (0..WIDTH-1). On `en`=1: `sh[bc]` <= `y`, `bc` <= `bc`+1. When `bc`=WIDTH-1, the word completes, `bc` wraps to 0, and the collector is free on the next sample. Collection never stalls.
- Output FSM, 2 states:
  - EMPTY: `out_valid`=0. On completion: load `out_data`/`out_ones`, go to FULL.
  - FULL: `out_valid`=1. Transfer occurs when `out_valid`&&`out_ready`.
    - Transfer without completion: go to EMPTY.
    - Completion with transfer in the same cycle: load the new word and stay in FULL. No overrun.
    - Completion without transfer: the new word is dropped, `out_data` is held, `overrun` <= 1, stay in FULL.
- `out_data`/`out_ones` are stable while `out_valid`=1 and no transfer has occurred.
- Rise detect: `prev` holds the last sampled `y`, reset value 0. A sample with `y`=1 and `prev`=0 increments `rise_cnt`. A first sample of 1 after reset counts as a rise.
- Run length: `run_cur` (8-bit, saturating) increments on each sampled 1 and clears on each sampled 0. `run_max` <= max(`run_max`, next `run_cur`), so it updates in the same cycle as the sample.
- `clr_stats`=1:
  - Zeroes `rise_cnt`, `run_max`, `run_cur` and `overrun`. Clear wins over a simultaneous increment or set.
  - `prev`, the collector and the output FSM are not affected.
- Reset:
  - All outputs go to 0, the FSM to EMPTY, and `bc`, `sh`, `prev` and `run_cur` to 0.
  - Reset mid-word discards the partial word.
  - Reset has priority over every other input.

## Timing
- Latency: the word's last sample edge (`en`=1, `bc`=WIDTH-1) is the same edge on which `out_valid` rises. Data is visible in the following cycle, one cycle after the final sample.
- `out_valid` falls on the edge after the accepting cycle, unless a word completes on that same edge.
- Back-to-back throughput: one word per WIDTH `en` strobes with `out_ready` tied high.
- Stats are visible one cycle after the sample edge. All outputs are registered; there are no combinational paths from input to output.
- `en` may be held continuously high. Gaps in `en` freeze all sampling state.

## Test plan
- Reset, WIDTH=8: hold `rst`=1 for 3 cycles. Every output is 0 and the FSM is EMPTY.
- Single word: with `out_ready`=0, sample `y`=1,0,1,1,0,0,1,0. Then `out_data`=8'h4D, `out_ones`=4, `out_valid`=1, `rise_cnt`=3, `run_max`=2.
- Handshake and overrun:
  - Keep `out_ready`=0 and send a second word of 8'hFF. `overrun`=1 and `out_data` stays 8'h4D.
  - Pulse `out_ready`. `out_valid`=0 on the next cycle.
- Simultaneous complete and accept: `out_ready` is high on the completing edge of 8'hAA while 8'h4D is pending. Result is `out_data`=8'hAA, `out_valid`=1, `overrun`=0.
- Saturation and clear:
  - Sample 300 consecutive 1s. `run_max`=255 and `rise_cnt` increments by 1.
  - Assert `clr_stats` on a rising sample. `rise_cnt`=0 and `run_max`=0.
- Reset mid-word: sample 5 bits, assert `rst`, then send 8 bits 8'h0F. `out_data`=8'h0F, so no stale bits leak through.
